// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared types for the bit-serial subtractor.
//   state_e : control FSM encoding (IDLE -> RUN -> DONE -> IDLE).
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
//   Combinational 1-bit subtractor cell: computes a - b - bin.
//   a_i, b_i, bin_i : minuend bit, subtrahend bit, borrow in
//   d_o             : difference bit
//   bout_o          : borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic ab_x;

  assign ab_x   = a_i ^ b_i;
  assign d_o    = ab_x ^ bin_i;
  // Borrow when b exceeds a outright, or when a==b and a borrow ripples in.
  assign bout_o = (~a_i & b_i) | (~ab_x & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor, LSB first, one bit per clock through a
//   single full_subtractor cell and one borrow flop. One operation in flight.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a_in, b_in)
//   out_valid/out_ready : result handshake (diff, borrow)
//   diff                : (a_in - b_in) mod 2^WIDTH
//   borrow              : 1 iff a_in < b_in
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit, bout_bit;

  full_subtractor u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (brw_q),
    .d_o    (d_bit),
    .bout_o (bout_bit)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // New bits enter at the MSB so bit 0 lands in res[0] after WIDTH shifts.
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        brw_d  = bout_bit;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags are pure state decodes; data comes straight from flops.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = res_q;
  assign borrow    = brw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench: accepted operands push the expected {borrow,diff} into a
//   queue; a negedge monitor pops and compares on each output handshake and
//   checks that a stalled result holds steady.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a_in, b_in;
  logic         out_valid, out_ready;
  logic [W-1:0] diff;
  logic         borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [W:0]  exp_q[$];
  int unsigned hs_cyc;
  bit          rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out (got no event, expected one)", name);
  endtask

  // Reference: plain integer subtraction, borrow from magnitude compare.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    d = (int'(a) - int'(b)) % (1 << W);
    if (d < 0) d += (1 << W);
    return {(a < b), W'(d)};
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = a; b_in = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) timeout("in_handshake");
    else begin
      if (push) exp_q.push_back(model(a, b));
      hs_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
  endtask

  // Monitor: compare on handshake, and require stability across stalls.
  logic         stall_q = 1'b0;
  logic [W-1:0] sd_q;
  logic         sb_q;
  logic [W:0]   e;
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'({borrow, diff}), 32'({sb_q, sd_q}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", {borrow, diff});
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({borrow, diff}), 32'(e));
        end
      end
      stall_q <= out_valid && !out_ready;
      sd_q    <= diff;
      sb_q    <= borrow;
    end else stall_q <= 1'b0;
  end

  task automatic wait_valid(input string name);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (n == 100) timeout(name);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);

    // Latency: first out_valid 9 cycles after the handshake.
    issue(8'd200, 8'd55, 1'b1);
    wait_valid("latency_wait");
    check("latency", cyc - hs_cyc, 32'(W + 1));
    check("result_200_55", 32'({borrow, diff}), {23'd0, 1'b0, 8'd145});
    drain();

    // Directed boundaries.
    issue(8'd5, 8'd10, 1'b1);
    issue(8'd0, 8'd1, 1'b1);
    issue(8'h80, 8'h80, 1'b1);
    issue(8'hFF, 8'h00, 1'b1);
    drain();

    // Backpressure with new operands held on the input.
    out_ready = 1'b0;
    issue(8'd20, 8'd3, 1'b1);
    wait_valid("bp_wait");
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = 8'h11; b_in = 8'h22;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_diff", 32'(diff), 32'd17);
      check("bp_borrow", 32'(borrow), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    issue(8'd7, 8'd9, 1'b1);
    drain();

    // Reset at RUN count 3, then a clean operation.
    issue(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    issue(8'd100, 8'd37, 1'b1);
    wait_valid("post_rst_wait");
    check("post_rst_100_37", 32'({borrow, diff}), {23'd0, 1'b0, 8'd63});
    drain();

    // Randomized traffic with gaps on both sides.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          issue(W'($urandom), W'($urandom), 1'b1);
        end
        drain();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
      end
    join
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("final_no_output", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
